// File: rtl/fetch_stage.sv
// fetch_stage -- IF stage and IF/ID pipeline register of the 5-stage MIPS core.
//
// Holds the PC, drives the asynchronous instruction ROM, hands PC_IF/INS_IF to
// jump_ctrl and loads jump_ctrl's NPC every cycle. A flush (clr) squashes the
// wrong-path instruction in IF, a stall holds PC and IF/ID, and fetch stops
// once the PC reaches MAX_INSADDR. Fetch/bubble performance counters are kept.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   NPC                   next PC from jump_ctrl (combinational from PC_IF/INS_IF)
//   clr                   flush: the instruction currently in IF is wrong-path
//   stall                 hold PC and IF/ID
//   imem_addr/imem_rdata  asynchronous instruction ROM port (addr == PC_IF)
//   PC_IF, INS_IF         current PC and its word (INS_IF = 0 when halted)
//   PC_ID, INS_ID         IF/ID register contents (INS_ID = 0 is a bubble)
//   valid_ID              INS_ID is a real instruction
//   halted                fetch has stopped
//   addr_err              sticky: a misaligned NPC was loaded into the PC
//   fetch_cnt, bubble_cnt valid fetches into ID / flush bubbles into ID
//   fsm_state             raw FSM state (0 = RUN, 1 = HALT) for observation
//
// Control semantics: there is no valid/ready handshake at this boundary. At
// every posedge the priority is rst > clr > stall > normal advance; stall is
// ignored while clr is high. clr/stall only affect registered state, so there
// is no combinational path from them to PC_IF.

module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      NPC,
  input  logic             clr,
  input  logic             stall,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      PC_IF,
  output logic [31:0]      INS_IF,
  output logic [31:0]      PC_ID,
  output logic [31:0]      INS_ID,
  output logic             valid_ID,
  output logic             halted,
  output logic             addr_err,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic             fsm_state
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [31:0]      pc, pc_n;
  logic [31:0]      pc_id_n, ins_id_n;
  logic             valid_n, err_n;
  logic [CNT_W-1:0] fetch_n, bubble_n;
  logic             pc_load;
  logic [31:0]      npc_aligned;
  logic             npc_misaligned;

  // A misaligned target is forced onto a word boundary and flagged.
  assign npc_aligned    = {NPC[31:2], 2'b00};
  assign npc_misaligned = |NPC[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      PC_ID      <= 32'h0;
      INS_ID     <= 32'h0;
      valid_ID   <= 1'b0;
      addr_err   <= 1'b0;
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      PC_ID      <= pc_id_n;
      INS_ID     <= ins_id_n;
      valid_ID   <= valid_n;
      addr_err   <= err_n;
      fetch_cnt  <= fetch_n;
      bubble_cnt <= bubble_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    pc_id_n  = PC_ID;
    ins_id_n = INS_ID;
    valid_n  = valid_ID;
    fetch_n  = fetch_cnt;
    bubble_n = bubble_cnt;
    err_n    = addr_err;
    pc_load  = 1'b0;

    case (state)
      RUN: begin
        if (clr) begin
          // Wrong-path word in IF becomes a counted bubble in ID.
          pc_n     = npc_aligned;
          pc_load  = 1'b1;
          pc_id_n  = pc;
          ins_id_n = 32'h0;
          valid_n  = 1'b0;
          bubble_n = bubble_cnt + 1'b1;
          if (NPC == MAX_INSADDR) state_n = HALT;
        end else if (!stall) begin
          pc_id_n  = pc;
          ins_id_n = imem_rdata;
          valid_n  = 1'b1;
          fetch_n  = fetch_cnt + 1'b1;
          // The last word is still latched; the PC then parks on it.
          if (pc == MAX_INSADDR) begin
            state_n = HALT;
          end else begin
            pc_n    = npc_aligned;
            pc_load = 1'b1;
          end
        end
      end
      HALT: begin
        // Bubbles fed into ID while halted are not flush bubbles: uncounted.
        if (clr) begin
          ins_id_n = 32'h0;
          valid_n  = 1'b0;
          // An older branch in ID resolving mispredicted restarts fetch.
          if (NPC < MAX_INSADDR) begin
            pc_n    = npc_aligned;
            pc_load = 1'b1;
            state_n = RUN;
          end
        end else if (!stall) begin
          ins_id_n = 32'h0;
          valid_n  = 1'b0;
        end
      end
      default: state_n = RUN;
    endcase

    if (pc_load && npc_misaligned) err_n = 1'b1;
  end

  assign imem_addr = pc;
  assign PC_IF     = pc;
  assign INS_IF    = (state == HALT) ? 32'h0 : imem_rdata;
  assign halted    = (state == HALT);
  assign fsm_state = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The DUT is built with MAX_INSADDR =
// 0x300C and 4-bit counters so halt and counter wrap are reachable quickly.
// The ROM returns 0xC000_0000 | address, so every expected word is derived
// from its address. NPC defaults to PC_IF + 4 unless a step overrides it.

module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] MAX_ADDR = 32'h0000_300C;
  localparam int          CNT_W    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             clr, stall;
  logic [31:0]      npc, imem_addr, imem_rdata;
  logic [31:0]      pc_if, ins_if, pc_id, ins_id;
  logic             valid_id, halted, addr_err, fsm_state;
  logic [CNT_W-1:0] fetch_cnt, bubble_cnt;

  logic             npc_ovr_en;
  logic [31:0]      npc_ovr;

  always_comb npc = npc_ovr_en ? npc_ovr : (pc_if + 32'd4);
  always_comb imem_rdata = 32'hC000_0000 | imem_addr;

  fetch_stage #(
    .RESET_PC   (RESET_PC),
    .MAX_INSADDR(MAX_ADDR),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .NPC       (npc),
    .clr       (clr),
    .stall     (stall),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .PC_IF     (pc_if),
    .INS_IF    (ins_if),
    .PC_ID     (pc_id),
    .INS_ID    (ins_id),
    .valid_ID  (valid_id),
    .halted    (halted),
    .addr_err  (addr_err),
    .fetch_cnt (fetch_cnt),
    .bubble_cnt(bubble_cnt),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] e_pc_if,
                        input logic [31:0] e_pc_id, input logic [31:0] e_ins_id,
                        input logic e_valid);
    chk({tag, ".PC_IF"},    pc_if,           e_pc_if);
    chk({tag, ".PC_ID"},    pc_id,           e_pc_id);
    chk({tag, ".INS_ID"},   ins_id,          e_ins_id);
    chk({tag, ".valid_ID"}, {31'h0, valid_id}, {31'h0, e_valid});
  endtask

  task automatic chk_reset(input string tag);
    chk_id(tag, RESET_PC, 32'h0, 32'h0, 1'b0);
    chk({tag, ".halted"},     {31'h0, halted},     32'h0);
    chk({tag, ".addr_err"},   {31'h0, addr_err},   32'h0);
    chk({tag, ".fetch_cnt"},  {28'h0, fetch_cnt},  32'h0);
    chk({tag, ".bubble_cnt"}, {28'h0, bubble_cnt}, 32'h0);
  endtask

  initial begin
    clr = 1'b0; stall = 1'b0; npc_ovr_en = 1'b0; npc_ovr = 32'h0;

    // 1. reset held two cycles, then sequential fetch
    rst = 1'b1;
    step(); step();
    chk_reset("reset");
    chk("reset.INS_IF", ins_if, rom(32'h3000));
    rst = 1'b0;
    step();
    chk_id("seq1", 32'h3004, 32'h3000, rom(32'h3000), 1'b1);
    step();
    chk_id("seq2", 32'h3008, 32'h3004, rom(32'h3004), 1'b1);
    step();
    chk_id("seq3", 32'h300C, 32'h3008, rom(32'h3008), 1'b1);
    chk("seq3.fetch_cnt", {28'h0, fetch_cnt}, 32'd3);

    // 2. flush redirects to 0x3040 and inserts a counted bubble
    clr = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h3040;
    step();
    clr = 1'b0; npc_ovr_en = 1'b0;
    chk_id("flush", 32'h3040, 32'h300C, 32'h0, 1'b0);
    chk("flush.bubble_cnt", {28'h0, bubble_cnt}, 32'd1);
    chk("flush.halted", {31'h0, halted}, 32'h0);
    step();
    chk_id("resume", 32'h3044, 32'h3040, rom(32'h3040), 1'b1);
    chk("resume.fetch_cnt", {28'h0, fetch_cnt}, 32'd4);

    // 3. stall holds everything; clr overrides stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_id("stall", 32'h3044, 32'h3040, rom(32'h3040), 1'b1);
      chk("stall.fetch_cnt", {28'h0, fetch_cnt}, 32'd4);
    end
    clr = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h3008;
    step();
    clr = 1'b0; stall = 1'b0; npc_ovr_en = 1'b0;
    chk_id("stall_clr", 32'h3008, 32'h3044, 32'h0, 1'b0);
    chk("stall_clr.bubble_cnt", {28'h0, bubble_cnt}, 32'd2);

    // 4. run into MAX_INSADDR: last word latched, then halt with bubbles
    step();
    chk_id("pre_max", 32'h300C, 32'h3008, rom(32'h3008), 1'b1);
    step();
    chk_id("at_max", 32'h300C, 32'h300C, rom(32'h300C), 1'b1);
    chk("at_max.halted", {31'h0, halted}, 32'h1);
    chk("at_max.INS_IF", ins_if, 32'h0);
    chk("at_max.fetch_cnt", {28'h0, fetch_cnt}, 32'd6);
    step();
    chk_id("halt_bub", 32'h300C, 32'h300C, 32'h0, 1'b0);
    chk("halt_bub.bubble_cnt", {28'h0, bubble_cnt}, 32'd2);
    chk("halt_bub.fetch_cnt", {28'h0, fetch_cnt}, 32'd6);
    // clr to a target not below MAX leaves fetch halted
    clr = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h3010;
    step();
    chk("halt_clr_hi.halted", {31'h0, halted}, 32'h1);
    chk("halt_clr_hi.PC_IF", pc_if, 32'h300C);
    // clr to an earlier target restarts fetch
    npc_ovr = 32'h3004;
    step();
    clr = 1'b0; npc_ovr_en = 1'b0;
    chk("restart.halted", {31'h0, halted}, 32'h0);
    chk("restart.PC_IF", pc_if, 32'h3004);
    chk("restart.bubble_cnt", {28'h0, bubble_cnt}, 32'd2);
    chk("restart.valid_ID", {31'h0, valid_id}, 32'h0);

    // 5. misaligned NPC is aligned and flags a sticky error
    npc_ovr_en = 1'b1; npc_ovr = 32'h3042;
    step();
    npc_ovr_en = 1'b0;
    chk_id("misal", 32'h3040, 32'h3004, rom(32'h3004), 1'b1);
    chk("misal.addr_err", {31'h0, addr_err}, 32'h1);
    step();
    chk("sticky1.PC_IF", pc_if, 32'h3044);
    chk("sticky1.addr_err", {31'h0, addr_err}, 32'h1);
    step();
    chk("sticky2.addr_err", {31'h0, addr_err}, 32'h1);
    chk("sticky2.fetch_cnt", {28'h0, fetch_cnt}, 32'd9);

    // 6. reset, then 17 fetches wrap the 4-bit counter to 1
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rst2");
    npc_ovr_en = 1'b1; npc_ovr = 32'h3100;
    step();
    npc_ovr_en = 1'b0;
    for (int i = 1; i < 16; i++) step();
    chk("wrap16.fetch_cnt", {28'h0, fetch_cnt}, 32'd0);
    chk("wrap16.PC_IF", pc_if, 32'h313C);
    step();
    chk("wrap17.fetch_cnt", {28'h0, fetch_cnt}, 32'd1);
    chk_id("wrap17", 32'h3140, 32'h313C, rom(32'h313C), 1'b1);
    // reset mid-stream
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rst_mid");

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
